fetch_stage: RTL and testbench

//  PC register, next-PC select and IF/ID pipeline register of the 5-stage RISC-V core.

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select, boot fill masking and IF/ID pipeline register.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 1,
    parameter logic [31:0] TRAP_PC     = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] PCPlus4F,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        TrapD,
    output logic [31:0] TrapPCD
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, TRAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] boot_cnt;
    logic [31:0]      redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;
    assign redirect_pc = PCTargetE;
    assign misalign    = PCSrcE && (PCTargetE[1:0] != 2'b00);
`else
    // Without the trap, low target bits are dropped so PCF stays word aligned.
    logic unused_cfg;
    assign redirect_pc = {PCTargetE[31:2], 2'b00};
    assign unused_cfg  = ^{PCTargetE[1:0], TRAP_PC};
    assign TrapD       = 1'b0;
    assign TrapPCD     = 32'h0000_0000;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            boot_cnt <= '0;
            PCF      <= RESET_PC;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            TrapD    <= 1'b0;
            TrapPCD  <= '0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            TrapD <= 1'b0;
`endif
            case (state)
                // Fill cycles: hold PC, push bubbles, ignore hazard controls.
                BOOT: begin
                    PCF      <= RESET_PC;
                    InstrD   <= NOP_INSTR;
                    PCD      <= '0;
                    PCPlus4D <= '0;
                    ValidD   <= 1'b0;
                    boot_cnt <= boot_cnt + CNT_W'(1);
                    if (boot_cnt == BOOT_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (misalign) begin
                        state    <= TRAP;
                        TrapPCD  <= PCTargetE;
                        InstrD   <= NOP_INSTR;
                        PCD      <= '0;
                        PCPlus4D <= '0;
                        ValidD   <= 1'b0;
                    end else
`endif
                    begin
                        // Redirect beats stall so a resolved branch is never lost.
                        if (PCSrcE) begin
                            PCF <= redirect_pc;
                        end else if (!StallF) begin
                            PCF <= PCPlus4F;
                        end
                        if (FlushD) begin
                            InstrD   <= NOP_INSTR;
                            PCD      <= '0;
                            PCPlus4D <= '0;
                            ValidD   <= 1'b0;
                        end else if (!StallD) begin
                            InstrD   <= InstrF;
                            PCD      <= PCF;
                            PCPlus4D <= PCPlus4F;
                            ValidD   <= 1'b1;
                        end
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                TRAP: begin
                    state    <= RUN;
                    PCF      <= TRAP_PC;
                    TrapD    <= 1'b1;
                    InstrD   <= NOP_INSTR;
                    PCD      <= '0;
                    PCPlus4D <= '0;
                    ValidD   <= 1'b0;
                end
`endif
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared cycle by cycle against a stage-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int unsigned BOOT_CYCLES = 2;
    localparam logic [31:0] TRAP_PC     = 32'h0000_0100;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] PCPlus4F, InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, TrapPCD;
    logic        ValidD, TrapD;

    int n_cmp = 0;
    int n_fail = 0;

    fetch_stage #(
        .RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT_CYCLES), .TRAP_PC(TRAP_PC), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .TrapD(TrapD), .TrapPCD(TrapPCD)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a fixed function of address.
    function automatic logic [31:0] imem(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h0050_0093;
        return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign InstrF   = imem(PCF);
    assign PCPlus4F = PCF + 32'd4;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_trappc;
    logic        m_valid, m_trap, m_trap_pend;
    int          m_boot_left;

    // Advance the model by one clock from the current inputs, then clock the DUT.
    task automatic cycle();
        logic [31:0] pc, instr, pcd, pc4d, trappc;
        logic        valid, trap, pend, bubble;
        int          boot_left;
        pc = m_pc; instr = m_instr; pcd = m_pcd; pc4d = m_pc4d; valid = m_valid;
        trappc = m_trappc; trap = 1'b0; pend = m_trap_pend; boot_left = m_boot_left;
        bubble = 1'b0;
        if (reset) begin
            pc = RESET_PC; bubble = 1'b1; trappc = 32'h0; pend = 1'b0;
            boot_left = BOOT_CYCLES;
        end else if (boot_left > 0) begin
            pc = RESET_PC; bubble = 1'b1; boot_left = boot_left - 1;
        end else if (pend) begin
            pc = TRAP_PC; trap = 1'b1; bubble = 1'b1; pend = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        end else if (PCSrcE && PCTargetE[1:0] != 2'b00) begin
            pend = 1'b1; trappc = PCTargetE; bubble = 1'b1;
`endif
        end else begin
            if (FlushD) bubble = 1'b1;
            else if (!StallD) begin
                instr = imem(m_pc); pcd = m_pc; pc4d = m_pc + 32'd4; valid = 1'b1;
            end
            if (PCSrcE) pc = PCTargetE & 32'hFFFF_FFFC;
            else if (!StallF) pc = m_pc + 32'd4;
        end
        if (bubble) begin
            instr = NOP; pcd = 32'h0; pc4d = 32'h0; valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc = pc; m_instr = instr; m_pcd = pcd; m_pc4d = pc4d; m_valid = valid;
        m_trap = trap; m_trappc = trappc; m_trap_pend = pend; m_boot_left = boot_left;
    endtask

    task automatic clear_inputs();
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        n_cmp++;
        if ({PCF, InstrD, PCD, PCPlus4D, ValidD, TrapD, TrapPCD} !==
            {RESET_PC, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got pcf=%h instr=%h pcd=%h pc4d=%h v=%b t=%b tpc=%h want pcf=%h instr=%h rest 0",
                     PCF, InstrD, PCD, PCPlus4D, ValidD, TrapD, TrapPCD, RESET_PC, NOP);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if ({PCF, InstrD, ValidD} !== {RESET_PC, NOP, 1'b0}) begin
                n_fail++;
                $display("FAIL boot_cycle%0d: got pcf=%h instr=%h v=%b want pcf=%h instr=%h v=0",
                         i, PCF, InstrD, ValidD, RESET_PC, NOP);
            end
        end
    endtask

    task automatic test_straight();
        cycle();
        n_cmp++;
        if ({InstrD, PCD, PCPlus4D, PCF, ValidD} !==
            {32'h0050_0093, 32'h0, 32'h4, 32'h4, 1'b1}) begin
            n_fail++;
            $display("FAIL straight_line: got instr=%h pcd=%h pc4d=%h pcf=%h v=%b want 00500093/0/4/4/1",
                     InstrD, PCD, PCPlus4D, PCF, ValidD);
        end
    endtask

    task automatic test_stall();
        cycle();
        n_cmp++;
        if (PCF !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_setup: got pcf=%h want 00000008", PCF);
        end
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if ({PCF, InstrD, PCD, ValidD} !== {32'h8, imem(32'h4), 32'h4, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pcf=%h instr=%h pcd=%h v=%b want 8/%h/4/1",
                         i, PCF, InstrD, PCD, ValidD, imem(32'h4));
            end
        end
        clear_inputs();
        cycle();
        n_cmp++;
        if ({PCF, PCD, ValidD} !== {32'hC, 32'h8, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_resume: got pcf=%h pcd=%h v=%b want c/8/1", PCF, PCD, ValidD);
        end
    endtask

    task automatic test_redirect_flush();
        PCSrcE = 1'b1; PCTargetE = 32'h40; FlushD = 1'b1; StallF = 1'b1;
        cycle();
        clear_inputs();
        n_cmp++;
        if ({PCF, InstrD, ValidD} !== {32'h40, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_flush: got pcf=%h instr=%h v=%b want 40/%h/0", PCF, InstrD, ValidD, NOP);
        end
    endtask

    task automatic test_misalign();
        PCSrcE = 1'b1; PCTargetE = 32'h42;
        cycle();
        clear_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++;
        if ({PCF, TrapPCD, ValidD, TrapD} !== {32'h40, 32'h42, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL trap_entry: got pcf=%h tpc=%h v=%b t=%b want 40/42/0/0", PCF, TrapPCD, ValidD, TrapD);
        end
        cycle();
        n_cmp++;
        if ({PCF, TrapD, ValidD, TrapPCD} !== {TRAP_PC, 1'b1, 1'b0, 32'h42}) begin
            n_fail++;
            $display("FAIL trap_pulse: got pcf=%h t=%b v=%b tpc=%h want %h/1/0/42", PCF, TrapD, ValidD, TrapPCD, TRAP_PC);
        end
        cycle();
        n_cmp++;
        if ({PCF, TrapD, TrapPCD} !== {TRAP_PC + 32'd4, 1'b0, 32'h42}) begin
            n_fail++;
            $display("FAIL trap_exit: got pcf=%h t=%b tpc=%h want %h/0/42", PCF, TrapD, TrapPCD, TRAP_PC + 32'd4);
        end
`else
        n_cmp++;
        if ({PCF, TrapD, TrapPCD, PCD, ValidD} !== {32'h40, 1'b0, 32'h0, 32'h40, 1'b1}) begin
            n_fail++;
            $display("FAIL misalign_forced: got pcf=%h t=%b tpc=%h pcd=%h v=%b want 40/0/0/40/1",
                     PCF, TrapD, TrapPCD, PCD, ValidD);
        end
`endif
    endtask

    task automatic test_wrap();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        cycle();
        clear_inputs();
        cycle();
        n_cmp++;
        if ({PCF, PCD, PCPlus4D, ValidD} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL pc_wrap: got pcf=%h pcd=%h pc4d=%h v=%b want 0/fffffffc/0/1", PCF, PCD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_mid_reset();
        PCSrcE = 1'b1; PCTargetE = 32'h24;
        cycle();
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_cmp++;
        if ({PCF, ValidD, InstrD} !== {RESET_PC, 1'b0, NOP}) begin
            n_fail++;
            $display("FAIL mid_reset: got pcf=%h v=%b instr=%h want %h/0/%h", PCF, ValidD, InstrD, RESET_PC, NOP);
        end
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if ({PCF, ValidD} !== {RESET_PC, 1'b0}) begin
                n_fail++;
                $display("FAIL reboot%0d: got pcf=%h v=%b want %h/0", i, PCF, ValidD, RESET_PC);
            end
        end
        clear_inputs();
        cycle();
        n_cmp++;
        if ({ValidD, PCD, PCF} !== {1'b1, RESET_PC, RESET_PC + 32'd4}) begin
            n_fail++;
            $display("FAIL reboot_run: got v=%b pcd=%h pcf=%h want 1/%h/%h", ValidD, PCD, PCF, RESET_PC, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 79) == 0);
            StallF    = ($urandom_range(0, 3) == 0);
            StallD    = ($urandom_range(0, 3) == 0);
            FlushD    = ($urandom_range(0, 3) == 0);
            PCSrcE    = ($urandom_range(0, 4) == 0);
            PCTargetE = $urandom;
            cycle();
            n_cmp++;
            if ({PCF, InstrD, PCD, PCPlus4D, ValidD, TrapD, TrapPCD} !==
                {m_pc, m_instr, m_pcd, m_pc4d, m_valid, m_trap, m_trappc}) begin
                n_fail++;
                $display("FAIL random[%0d]: got pcf=%h instr=%h pcd=%h pc4d=%h v=%b t=%b tpc=%h want %h/%h/%h/%h/%b/%b/%h",
                         i, PCF, InstrD, PCD, PCPlus4D, ValidD, TrapD, TrapPCD,
                         m_pc, m_instr, m_pcd, m_pc4d, m_valid, m_trap, m_trappc);
            end
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_trappc = 32'h0;
        m_valid = 1'b0; m_trap = 1'b0; m_trap_pend = 1'b0; m_boot_left = BOOT_CYCLES;
        test_reset();
        test_straight();
        test_stall();
        test_redirect_flush();
        test_misalign();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
